// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared CPU package for the memory port arbiter. Holds the
//               arbiter FSM state encoding, the transaction owner encoding
//               and the default starvation limit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Maximum number of back-to-back LSU grants while a fetch is waiting.
    localparam int C_STARVE_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [0:0] {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_grant
// Description : Grant selection between the fetch (IF) and load/store (LSU)
//               requesters. LSU is favoured; once the LSU has been granted
//               STARVE_MAX times in a row while IF was waiting, IF wins.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               en                - arbitration allowed this cycle
//               if_req_valid      - fetch request pending
//               lsu_req_valid     - load/store request pending
//               if_grant          - fetch wins this cycle
//               lsu_grant         - load/store wins this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_grant #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic if_req_valid,
    input  logic lsu_req_valid,
    output logic if_grant,
    output logic lsu_grant
);

    // Counter must be able to hold STARVE_MAX itself; keep at least one bit.
    localparam int C_CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [C_CW-1:0] C_MAX = C_CW'(STARVE_MAX);

    logic [C_CW-1:0] r_starve;
    logic            w_if_forced;

    assign w_if_forced = if_req_valid && (r_starve == C_MAX);
    assign lsu_grant   = en && lsu_req_valid && !w_if_forced;
    assign if_grant    = en && if_req_valid && !lsu_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (if_grant) begin
            r_starve <= '0;
        end else if (lsu_grant && if_req_valid && (r_starve != C_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and the
//               load/store unit. One transaction outstanding at a time:
//               IDLE (accept) -> ISSUE (drive memory request) -> WAIT
//               (await response) -> IDLE. The response is registered and
//               returned to the owner as a one-cycle rvalid pulse.
// Ports       : clk, rst                          - clock, sync reset
//               if_req_valid/ready, if_addr       - fetch request
//               if_rvalid, if_rdata               - fetch response
//               lsu_req_valid/ready, lsu_addr,
//               lsu_wen, lsu_wdata, lsu_wmask     - load/store request
//               lsu_rvalid, lsu_rdata             - load data / store ack
//               mem_req_valid/ready, mem_addr,
//               mem_wen, mem_wdata, mem_wmask     - shared memory request
//               mem_rvalid, mem_rdata             - shared memory response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int STARVE_MAX = C_STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [XLEN-1:0]   lsu_addr,
    input  logic              lsu_wen,
    input  logic [XLEN-1:0]   lsu_wdata,
    input  logic [XLEN/8-1:0] lsu_wmask,
    output logic              lsu_rvalid,
    output logic [XLEN-1:0]   lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    arb_owner_e        r_owner;
    logic [XLEN-1:0]   r_addr;
    logic              r_wen;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN/8-1:0] r_wmask;
    logic              r_if_rvalid;
    logic              r_lsu_rvalid;
    logic [XLEN-1:0]   r_if_rdata;
    logic [XLEN-1:0]   r_lsu_rdata;

    logic w_grant_en;
    logic w_if_grant;
    logic w_lsu_grant;
    logic w_resp;

    // Ready is combinational, so it must also be held low during reset.
    assign w_grant_en = (r_state == ST_IDLE) && !rst;
    // Responses outside WAIT (including stale ones after reset) are dropped.
    assign w_resp     = (r_state == ST_WAIT) && mem_rvalid;

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clk           (clk),
        .rst           (rst),
        .en            (w_grant_en),
        .if_req_valid  (if_req_valid),
        .lsu_req_valid (lsu_req_valid),
        .if_grant      (w_if_grant),
        .lsu_grant     (w_lsu_grant)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_if_grant || w_lsu_grant) w_state_next = ST_ISSUE;
            ST_ISSUE: if (mem_req_ready)             w_state_next = ST_WAIT;
            ST_WAIT:  if (mem_rvalid)                w_state_next = ST_IDLE;
            default:                                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_IF;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_if_rvalid  <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_if_rdata   <= '0;
            r_lsu_rdata  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_if_rvalid  <= 1'b0;
            r_lsu_rvalid <= 1'b0;

            // Fetches are always plain reads: write controls forced to zero.
            if (w_if_grant) begin
                r_owner <= OWN_IF;
                r_addr  <= if_addr;
                r_wen   <= 1'b0;
                r_wdata <= '0;
                r_wmask <= '0;
            end else if (w_lsu_grant) begin
                r_owner <= OWN_LSU;
                r_addr  <= lsu_addr;
                r_wen   <= lsu_wen;
                r_wdata <= lsu_wdata;
                r_wmask <= lsu_wmask;
            end

            // Store acks also capture mem_rdata into lsu_rdata.
            if (w_resp) begin
                if (r_owner == OWN_LSU) begin
                    r_lsu_rvalid <= 1'b1;
                    r_lsu_rdata  <= mem_rdata;
                end else begin
                    r_if_rvalid  <= 1'b1;
                    r_if_rdata   <= mem_rdata;
                end
            end
        end
    end

    assign if_req_ready  = w_if_grant;
    assign lsu_req_ready = w_lsu_grant;
    assign mem_req_valid = (r_state == ST_ISSUE);
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;
    assign if_rvalid     = r_if_rvalid;
    assign if_rdata      = r_if_rdata;
    assign lsu_rvalid    = r_lsu_rvalid;
    assign lsu_rdata     = r_lsu_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A transaction-level
//               model predicts every output each cycle; directed sequences
//               add literal expectations for the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int XLEN       = 64;
    localparam int STARVE_MAX = 4;

    logic              clk;
    logic              rst;
    logic              if_req_valid;
    logic              if_req_ready;
    logic [XLEN-1:0]   if_addr;
    logic              if_rvalid;
    logic [XLEN-1:0]   if_rdata;
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [XLEN-1:0]   lsu_addr;
    logic              lsu_wen;
    logic [XLEN-1:0]   lsu_wdata;
    logic [XLEN/8-1:0] lsu_wmask;
    logic              lsu_rvalid;
    logic [XLEN-1:0]   lsu_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [XLEN-1:0]   mem_addr;
    logic              mem_wen;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wmask;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    int n_cmp = 0;
    int n_err = 0;
    bit mdl_on = 0;

    mem_port_arbiter #(
        .XLEN       (XLEN),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_addr       (if_addr),
        .if_rvalid     (if_rvalid),
        .if_rdata      (if_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rvalid    (lsu_rvalid),
        .lsu_rdata     (lsu_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the
    // falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model. At each falling edge it predicts the
    // outputs from "is a transaction open / has memory taken it" plus the
    // count of LSU wins since IF last won, then advances to the state the
    // next rising edge produces from the (stable) current inputs.
    // ------------------------------------------------------------------
    bit              m_open, m_sent, m_lsu_owner, m_wen;
    bit              m_if_pulse, m_lsu_pulse;
    int              m_lsu_wins;
    logic [63:0]     m_addr, m_wdata, m_if_rdata, m_lsu_rdata;
    logic [7:0]      m_wmask;

    initial begin
        m_open = 0; m_sent = 0; m_lsu_owner = 0; m_wen = 0;
        m_if_pulse = 0; m_lsu_pulse = 0; m_lsu_wins = 0;
        m_addr = '0; m_wdata = '0; m_wmask = '0;
        m_if_rdata = '0; m_lsu_rdata = '0;
        forever begin
            bit can_take, if_turn, e_lsu_rdy, e_if_rdy, e_mreq;
            @(negedge clk);
            if (mdl_on) begin
                can_take  = !m_open && !rst;
                if_turn   = if_req_valid && (m_lsu_wins >= STARVE_MAX);
                e_lsu_rdy = can_take && lsu_req_valid && !if_turn;
                e_if_rdy  = can_take && if_req_valid && !e_lsu_rdy;
                e_mreq    = m_open && !m_sent;

                check("mdl_lsu_req_ready", 64'(lsu_req_ready), 64'(e_lsu_rdy));
                check("mdl_if_req_ready",  64'(if_req_ready),  64'(e_if_rdy));
                check("mdl_mem_req_valid", 64'(mem_req_valid), 64'(e_mreq));
                if (e_mreq) begin
                    check("mdl_mem_addr",  mem_addr,         m_addr);
                    check("mdl_mem_wen",   64'(mem_wen),     64'(m_wen));
                    check("mdl_mem_wdata", mem_wdata,        m_wdata);
                    check("mdl_mem_wmask", 64'(mem_wmask),   64'(m_wmask));
                end
                check("mdl_if_rvalid",  64'(if_rvalid),  64'(m_if_pulse));
                check("mdl_lsu_rvalid", 64'(lsu_rvalid), 64'(m_lsu_pulse));
                check("mdl_if_rdata",   if_rdata,        m_if_rdata);
                check("mdl_lsu_rdata",  lsu_rdata,       m_lsu_rdata);

                m_if_pulse  = 0;
                m_lsu_pulse = 0;
                if (rst) begin
                    m_open = 0; m_sent = 0; m_lsu_wins = 0;
                    m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
                    m_if_rdata = '0; m_lsu_rdata = '0;
                end else if (m_open && m_sent) begin
                    if (mem_rvalid) begin
                        m_open = 0;
                        if (m_lsu_owner) begin
                            m_lsu_pulse = 1; m_lsu_rdata = mem_rdata;
                        end else begin
                            m_if_pulse = 1; m_if_rdata = mem_rdata;
                        end
                    end
                end else if (m_open) begin
                    if (mem_req_ready) m_sent = 1;
                end else if (e_lsu_rdy) begin
                    m_open = 1; m_sent = 0; m_lsu_owner = 1;
                    m_addr = lsu_addr; m_wen = lsu_wen;
                    m_wdata = lsu_wdata; m_wmask = lsu_wmask;
                    if (if_req_valid && m_lsu_wins < STARVE_MAX) m_lsu_wins++;
                end else if (e_if_rdy) begin
                    m_open = 1; m_sent = 0; m_lsu_owner = 0;
                    m_addr = if_addr; m_wen = 0; m_wdata = '0; m_wmask = '0;
                    m_lsu_wins = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        string seq;
        rst = 1; if_req_valid = 0; if_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_rvalid = 0; mem_rdata = '0;

        // Reset: outputs zero, no ready even with requests pending.
        step();
        mdl_on = 1;
        if_req_valid = 1; lsu_req_valid = 1;
        @(negedge clk);
        check("rst_if_ready",  64'(if_req_ready),  64'd0);
        check("rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
        check("rst_mreq",      64'(mem_req_valid), 64'd0);
        check("rst_if_rdata",  if_rdata,           64'd0);
        check("rst_lsu_rdata", lsu_rdata,          64'd0);
        step();
        rst = 0; if_req_valid = 0; lsu_req_valid = 0;

        // Single fetch, response two cycles after the memory request.
        if_req_valid = 1; if_addr = 64'h0000_0000_8000_0000; mem_req_ready = 1;
        @(negedge clk);
        check("f_c0_if_ready", 64'(if_req_ready),  64'd1);
        check("f_c0_mreq",     64'(mem_req_valid), 64'd0);
        step(); if_req_valid = 0;
        @(negedge clk);
        check("f_c1_mreq",     64'(mem_req_valid), 64'd1);
        check("f_c1_addr",     mem_addr,           64'h0000_0000_8000_0000);
        check("f_c1_wen",      64'(mem_wen),       64'd0);
        step();
        @(negedge clk);
        check("f_c2_mreq",     64'(mem_req_valid), 64'd0);
        step(); mem_rvalid = 1; mem_rdata = 64'h0000_0013_0000_0297;
        @(negedge clk);
        check("f_c3_if_rvalid", 64'(if_rvalid), 64'd0);
        step(); mem_rvalid = 0; mem_rdata = '0;
        @(negedge clk);
        check("f_c4_if_rvalid", 64'(if_rvalid), 64'd1);
        check("f_c4_if_rdata",  if_rdata,       64'h0000_0013_0000_0297);
        check("f_c4_lsu_rvalid",64'(lsu_rvalid),64'd0);
        step();
        @(negedge clk);
        check("f_c5_if_rvalid", 64'(if_rvalid), 64'd0);
        check("f_c5_if_rdata",  if_rdata,       64'h0000_0013_0000_0297);

        // Both valid: LSU first, IF in the IDLE cycle of the LSU response.
        step();
        if_req_valid = 1; if_addr = 64'h8000_0008;
        lsu_req_valid = 1; lsu_addr = 64'h8000_0100; lsu_wen = 0;
        @(negedge clk);
        check("b_lsu_ready", 64'(lsu_req_ready), 64'd1);
        check("b_if_ready",  64'(if_req_ready),  64'd0);
        step(); lsu_req_valid = 0;
        step(); mem_rvalid = 1; mem_rdata = 64'hA5A5_5A5A_0123_4567;
        step(); mem_rvalid = 0;
        @(negedge clk);
        check("b_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
        check("b_lsu_rdata",  lsu_rdata,       64'hA5A5_5A5A_0123_4567);
        check("b_if_ready2",  64'(if_req_ready), 64'd1);
        step(); if_req_valid = 0;
        step(); mem_rvalid = 1; mem_rdata = 64'h0000_0000_0000_0013;
        step(); mem_rvalid = 0;
        @(negedge clk);
        check("b_if_rvalid", 64'(if_rvalid), 64'd1);
        step();

        // Starvation pattern under continuous requests from both sides.
        rst = 1; step(); rst = 0;
        if_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1; mem_rvalid = 1;
        seq = "";
        for (int c = 0; c < 60 && seq.len() < 10; c++) begin
            mem_rdata = {$urandom, $urandom};
            lsu_wen   = c[0];
            lsu_wdata = {$urandom, $urandom};
            lsu_wmask = 8'($urandom);
            lsu_addr  = 64'h8000_2000 + 64'(c * 8);
            if_addr   = 64'h8000_4000 + 64'(c * 8);
            @(negedge clk);
            if (lsu_req_ready) seq = {seq, "L"};
            if (if_req_ready)  seq = {seq, "I"};
            step();
        end
        n_cmp++;
        if (seq != "LLLLILLLLI") begin
            n_err++;
            $display("FAIL starve_seq: got %s expected LLLLILLLLI", seq);
        end
        if_req_valid = 0; lsu_req_valid = 0;
        repeat (3) step();
        mem_rvalid = 0; mem_req_ready = 0; lsu_wen = 0;
        step();

        // Store with memory back-pressure for three cycles.
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 64'h8000_1000;
        lsu_wdata = 64'h1122_3344_5566_7788; lsu_wmask = 8'h0F;
        @(negedge clk);
        check("s_lsu_ready", 64'(lsu_req_ready), 64'd1);
        step();
        lsu_req_valid = 0; lsu_addr = '1; lsu_wdata = '0; lsu_wmask = 8'hFF; lsu_wen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("s_hold_mreq",  64'(mem_req_valid), 64'd1);
            check("s_hold_addr",  mem_addr,           64'h8000_1000);
            check("s_hold_wdata", mem_wdata,          64'h1122_3344_5566_7788);
            check("s_hold_wmask", 64'(mem_wmask),     64'h0F);
            check("s_hold_wen",   64'(mem_wen),       64'd1);
            step();
        end
        mem_req_ready = 1;
        @(negedge clk);
        check("s_hs_mreq", 64'(mem_req_valid), 64'd1);
        step(); mem_req_ready = 0; mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(negedge clk);
        check("s_wait_mreq", 64'(mem_req_valid), 64'd0);
        step(); mem_rvalid = 0;
        @(negedge clk);
        check("s_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
        check("s_lsu_rdata",  lsu_rdata,       64'hDEAD_BEEF_CAFE_F00D);
        check("s_if_rvalid",  64'(if_rvalid),  64'd0);
        step();
        @(negedge clk);
        check("s_lsu_rvalid_end", 64'(lsu_rvalid), 64'd0);

        // Reset while waiting for a response; the late response is dropped.
        step();
        if_req_valid = 1; if_addr = 64'h8000_0040; mem_req_ready = 1;
        step(); if_req_valid = 0;
        step(); mem_req_ready = 0; rst = 1;
        step(); rst = 0; mem_rvalid = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        check("r_mreq",      64'(mem_req_valid), 64'd0);
        check("r_mem_addr",  mem_addr,           64'd0);
        check("r_if_rdata",  if_rdata,           64'd0);
        check("r_lsu_rdata", lsu_rdata,          64'd0);
        step(); mem_rvalid = 0; if_req_valid = 1; if_addr = 64'h8000_0080;
        @(negedge clk);
        check("r_if_rvalid",  64'(if_rvalid),    64'd0);
        check("r_lsu_rvalid", 64'(lsu_rvalid),   64'd0);
        check("r_if_rdata2",  if_rdata,          64'd0);
        check("r_idle_ready", 64'(if_req_ready), 64'd1);
        step(); if_req_valid = 0; mem_req_ready = 1;
        step(); mem_req_ready = 0; mem_rvalid = 1; mem_rdata = 64'h55;
        step(); mem_rvalid = 0;
        @(negedge clk);
        check("r_after_if_rdata", if_rdata, 64'h55);
        repeat (2) step();

        mdl_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
